// File: rtl/crtc_timing.sv
// crtc_timing: 6845-compatible CRTC timing generator for the PET video path.
// Holds R0..R17, and generates hsync/vsync/de and the video address MA/RA,
// advancing on the character-clock enable.
module crtc_timing #(
  parameter int MA_WIDTH    = 14,
  parameter int RA_WIDTH    = 5,
  parameter int VSYNC_LINES = 16,
  parameter int R0_INIT     = 63,
  parameter int R1_INIT     = 40,
  parameter int R2_INIT     = 50,
  parameter int R3_INIT     = 4,
  parameter int R4_INIT     = 31,
  parameter int R5_INIT     = 5,
  parameter int R6_INIT     = 25,
  parameter int R7_INIT     = 28,
  parameter int R9_INIT     = 7
) (
  input  logic                clk16,
  input  logic                res_b,
  input  logic                char_en,
  input  logic [4:0]          reg_addr,
  input  logic [7:0]          reg_wdata,
  input  logic                reg_we,
  input  logic                reg_re,
  output logic [7:0]          reg_rdata,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [MA_WIDTH-1:0] ma,
  output logic [RA_WIDTH-1:0] ra
);

  localparam int VS_W = $clog2(VSYNC_LINES + 1);

  typedef enum logic {ACTIVE, ADJUST} vstate_t;

  logic [7:0]          regs [0:17];
  logic [7:0]          h_cnt, row_cnt, adj_cnt;
  logic [MA_WIDTH-1:0] ma_row;
  logic [VS_W-1:0]     vs_left;
  vstate_t             state, state_nxt;

  logic [7:0]          h_nxt, row_nxt, adj_nxt;
  logic [RA_WIDTH-1:0] ra_nxt;
  logic [MA_WIDTH-1:0] ma_row_nxt, ma_nxt, start_addr;
  logic [VS_W-1:0]     vs_nxt;
  logic                eol, eof, hs_nxt, de_nxt;
  logic [3:0]          hs_width;

  // Register file: writes, registered reads, reset to the programmed defaults.
  always_ff @(posedge clk16) begin
    if (!res_b) begin
      for (int unsigned i = 0; i < 18; i++) regs[i] <= '0;
      regs[0]   <= 8'(R0_INIT);
      regs[1]   <= 8'(R1_INIT);
      regs[2]   <= 8'(R2_INIT);
      regs[3]   <= 8'(R3_INIT);
      regs[4]   <= 8'(R4_INIT);
      regs[5]   <= 8'(R5_INIT);
      regs[6]   <= 8'(R6_INIT);
      regs[7]   <= 8'(R7_INIT);
      regs[9]   <= 8'(R9_INIT);
      reg_rdata <= '0;
    end else begin
      if (reg_we && (reg_addr < 5'd18)) regs[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= (reg_addr < 5'd18) ? regs[reg_addr] : '0;
    end
  end

  // Next-state of all counters and of the outputs for the cell being entered.
  always_comb begin
    start_addr = MA_WIDTH'({regs[13][5:0], regs[12]});
    eol        = (h_cnt >= regs[0]);
    h_nxt      = eol ? '0 : h_cnt + 8'd1;
    ra_nxt     = ra;
    row_nxt    = row_cnt;
    adj_nxt    = adj_cnt;
    state_nxt  = state;
    ma_row_nxt = ma_row;
    vs_nxt     = vs_left;
    eof        = 1'b0;
    if (eol) begin
      case (state)
        ACTIVE: begin
          if (ra >= RA_WIDTH'(regs[9][4:0])) begin
            ma_row_nxt = ma_row + MA_WIDTH'(regs[1]);
            if (row_cnt >= regs[4]) begin
              if (regs[5] == 8'd0) begin
                eof = 1'b1;
              end else begin
                state_nxt = ADJUST;
                adj_nxt   = '0;
                ra_nxt    = ra + RA_WIDTH'(1);
              end
            end else begin
              row_nxt = row_cnt + 8'd1;
              ra_nxt  = '0;
            end
          end else begin
            ra_nxt = ra + RA_WIDTH'(1);
          end
        end
        ADJUST: begin
          ra_nxt  = ra + RA_WIDTH'(1);
          adj_nxt = adj_cnt + 8'd1;
          if ((9'(adj_cnt) + 9'd1) >= 9'(regs[5])) eof = 1'b1;
        end
        default: state_nxt = ACTIVE;
      endcase
      if (eof) begin
        state_nxt  = ACTIVE;
        row_nxt    = '0;
        ra_nxt     = '0;
        adj_nxt    = '0;
        ma_row_nxt = start_addr;
      end
      // vsync is retriggered on entering line 0 of row R7; otherwise it counts lines down
      if ((state_nxt == ACTIVE) && (ra_nxt == '0) && (row_nxt == regs[7]) &&
          (regs[7] <= regs[4]))
        vs_nxt = VS_W'(VSYNC_LINES);
      else if (vs_left != '0)
        vs_nxt = vs_left - VS_W'(1);
    end
    hs_width = regs[3][3:0];
    hs_nxt   = ({1'b0, h_nxt} >= {1'b0, regs[2]}) &&
               ({1'b0, h_nxt} < ({1'b0, regs[2]} + ((hs_width == 4'd0) ? 9'd16 : 9'(hs_width))));
    de_nxt   = (h_nxt < regs[1]) && (row_nxt < regs[6]) && (state_nxt == ACTIVE);
    ma_nxt   = ma_row_nxt + MA_WIDTH'(h_nxt);
  end

  // Counters and output registers advance together on each character strobe,
  // outputs being taken from the next-state values so they match the new cell.
  always_ff @(posedge clk16) begin
    if (!res_b) begin
      h_cnt   <= '0;
      ra      <= '0;
      row_cnt <= '0;
      adj_cnt <= '0;
      state   <= ACTIVE;
      ma_row  <= '0;
      ma      <= '0;
      vs_left <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      de      <= 1'b0;
    end else if (char_en) begin
      h_cnt   <= h_nxt;
      ra      <= ra_nxt;
      row_cnt <= row_nxt;
      adj_cnt <= adj_nxt;
      state   <= state_nxt;
      ma_row  <= ma_row_nxt;
      ma      <= ma_nxt;
      vs_left <= vs_nxt;
      hsync   <= hs_nxt;
      vsync   <= (vs_nxt != '0);
      de      <= de_nxt;
    end
  end

endmodule

// File: tb/tb_crtc_timing.sv
// tb_crtc_timing: directed self-checking bench for crtc_timing.
module tb_crtc_timing;

  logic        clk16 = 1'b0;
  logic        res_b = 1'b0;
  logic        char_en = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [7:0]  reg_wdata = '0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [7:0]  reg_rdata;
  logic        hsync, vsync, de;
  logic [13:0] ma;
  logic [4:0]  ra;

  int n_checks = 0;
  int n_pass   = 0;

  crtc_timing #(.VSYNC_LINES(4)) dut (
    .clk16(clk16), .res_b(res_b), .char_en(char_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .hsync(hsync), .vsync(vsync), .de(de), .ma(ma), .ra(ra)
  );

  always #5 clk16 = ~clk16;

  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    reg_addr = a; reg_re = 1'b1;
    tick();
    reg_re = 1'b0;
  endtask

  initial begin
    int l, h, base;

    // Reset with char_en toggling
    for (int i = 0; i < 3; i++) begin
      char_en = (i % 2 == 0);
      tick();
    end
    char_en = 1'b0;
    chk("rst_hsync", 32'(hsync), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_ma", 32'(ma), 0);
    chk("rst_ra", 32'(ra), 0);
    chk("rst_rdata", 32'(reg_rdata), 0);
    res_b = 1'b1;
    rd(5'd0);
    chk("rst_r0", 32'(reg_rdata), 63);

    // Small frame: 10 chars/line, 2 lines/row, 3 rows, 1 adjust line
    wr(5'd0, 8'd9); wr(5'd1, 8'd4); wr(5'd2, 8'd6); wr(5'd3, 8'd2);
    wr(5'd9, 8'd1); wr(5'd4, 8'd2); wr(5'd5, 8'd1); wr(5'd6, 8'd2); wr(5'd7, 8'd1);

    // Cell k of the run: line (k%70)/10, column k%10; R12 written mid frame 1
    char_en = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      if (k == 100) begin
        reg_addr = 5'd12; reg_wdata = 8'h10; reg_we = 1'b1;
      end
      tick();
      reg_we = 1'b0;
      l    = (k % 70) / 10;
      h    = k % 10;
      base = (k >= 140) ? 16 : 0;
      chk("frm_ma", 32'(ma), 32'(base + 4 * (l / 2) + h));
      chk("frm_ra", 32'(ra), 32'((l == 6) ? 2 : (l % 2)));
      chk("frm_de", 32'(de), 32'((h < 4) && (l < 4)));
      chk("frm_hsync", 32'(hsync), 32'((h == 6) || (h == 7)));
      chk("frm_vsync", 32'(vsync), 32'((l >= 2) && (l <= 5)));
    end

    // char_en low: everything holds at line 1, column 0 of the new frame
    char_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_ma", 32'(ma), 16);
      chk("frz_ra", 32'(ra), 1);
      chk("frz_de", 32'(de), 1);
    end

    // Shrink R0 below the current column
    char_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("h7_ma", 32'(ma), 23);
    chk("h7_hsync", 32'(hsync), 1);
    char_en = 1'b0;
    wr(5'd0, 8'd2);
    char_en = 1'b1;
    tick();
    chk("wrap_ma", 32'(ma), 20);
    chk("wrap_ra", 32'(ra), 0);
    chk("wrap_vsync", 32'(vsync), 1);
    chk("wrap_de", 32'(de), 1);
    tick(); chk("short_ma1", 32'(ma), 21);
    tick(); chk("short_ma2", 32'(ma), 22);
    tick();
    chk("short_ma0", 32'(ma), 20);
    chk("short_ra", 32'(ra), 1);

    // R3=0: 16-wide hsync clipped at end of a 21-char line
    char_en = 1'b0;
    wr(5'd0, 8'd20); wr(5'd2, 8'd10); wr(5'd3, 8'd0);
    char_en = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk("clip_hsync", 32'(hsync), 32'((i % 21) >= 10));
    end

    // Pulse running past column 255 must not wrap into the next line
    char_en = 1'b0;
    wr(5'd0, 8'd255); wr(5'd2, 8'd250);
    char_en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk("wide_hsync", 32'(hsync), 32'((i % 256) >= 250));
    end
    char_en = 1'b0;

    // Register file
    wr(5'd17, 8'hA5); rd(5'd17);
    chk("r17", 32'(reg_rdata), 32'hA5);
    wr(5'd3, 8'hF2); rd(5'd3);
    chk("r3_full", 32'(reg_rdata), 32'hF2);
    wr(5'd20, 8'h77); rd(5'd20);
    chk("r20", 32'(reg_rdata), 0);
    reg_addr = 5'd1; reg_wdata = 8'h33; reg_we = 1'b1; reg_re = 1'b1;
    tick();
    reg_we = 1'b0; reg_re = 1'b0;
    chk("rw_old", 32'(reg_rdata), 4);
    tick();
    chk("rd_hold", 32'(reg_rdata), 4);
    rd(5'd1);
    chk("rw_new", 32'(reg_rdata), 32'h33);

    // Reset mid-frame beats a concurrent write
    char_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    res_b = 1'b0; reg_addr = 5'd0; reg_wdata = 8'h11; reg_we = 1'b1;
    tick(); tick();
    chk("mrst_ma", 32'(ma), 0);
    chk("mrst_de", 32'(de), 0);
    chk("mrst_rdata", 32'(reg_rdata), 0);
    res_b = 1'b1; reg_we = 1'b0; char_en = 1'b0;
    rd(5'd0);
    chk("mrst_r0", 32'(reg_rdata), 63);
    rd(5'd1);
    chk("mrst_r1", 32'(reg_rdata), 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crtc_timing.md
Name: crtc_timing

Overview:
- 6845-compatible CRTC timing generator for the PET video path. It is the parametrised successor to the fixed 60 Hz hvSync counter and the passive R0..R17 register file.
- Holds the CRTC programming registers and uses them to generate:
  - hsync and vsync,
  - display enable,
  - the video memory address (MA) and the row/scan-line address (RA).
- Counters advance on a character-clock enable derived from clk16, so 40- and 80-column modes differ only in enable rate and register values.

Parameters:
MA_WIDTH, 14, width of memory address output; all MA arithmetic is modulo 2^MA_WIDTH
RA_WIDTH, 5, width of scan-line (raster) address
VSYNC_LINES, 16, vsync pulse length in scan lines (fixed, 6845 behaviour)
R0_INIT, 63, reset value of horizontal total (chars per line minus 1)
R1_INIT, 40, reset value of horizontal displayed
R2_INIT, 50, reset value of hsync position
R3_INIT, 4, reset value of hsync width (low nibble, 0 means 16)
R4_INIT, 31, reset value of vertical total (rows minus 1)
R5_INIT, 5, reset value of vertical total adjust (scan lines)
R6_INIT, 25, reset value of vertical displayed rows
R7_INIT, 28, reset value of vsync row position
R9_INIT, 7, reset value of max scan line (scan lines per row minus 1)

Ports:
clk16  input  1  16 MHz system clock; all logic on posedge
res_b  input  1  synchronous active-low reset
char_en  input  1  one-clk16 strobe per character time; counters advance only when high
reg_addr  input  5  register select R0..R17
reg_wdata  input  8  write data
reg_we  input  1  synchronous write strobe, sampled on posedge clk16
reg_re  input  1  synchronous read strobe
reg_rdata  output  8  read data, registered
hsync  output  1  horizontal sync, active high
vsync  output  1  vertical sync, active high
de  output  1  display enable
ma  output  MA_WIDTH  video memory address of current character
ra  output  RA_WIDTH  scan line within current character row

Behaviour:
- Reset (res_b low at posedge):
  - Registers load the *_INIT values; R8, R10..R17 load 0.
  - h_cnt, ra, row_cnt and adj_cnt load 0; ma and ma_row load {R13,R12}=0.
  - hsync, vsync, de and reg_rdata load 0.
  - Reset applies mid-frame identically. Reset overrides reg_we.
- Register writes: on reg_we, r[reg_addr] <= reg_wdata.
  - Addresses 18..31 are ignored.
  - R3 and R9 store all 8 bits; only the documented bits are used.
- Register reads: on reg_re, reg_rdata <= r[reg_addr] the next cycle.
  - Addresses 18..31 read 0.
  - reg_rdata holds its value until the next reg_re.
  - Simultaneous reg_we and reg_re to the same address return the old value.
- Horizontal: when char_en is high and h_cnt >= R0, h_cnt <= 0 (end of line); otherwise h_cnt increments.
  - The >= compare means that lowering R0 below h_cnt ends the line at the next char_en and never runs away.
- Vertical, evaluated at end of line:
  - In a normal row, if ra >= R9[4:0] then ra <= 0 (end of row), else ra increments.
  - At end of row, if row_cnt >= R4:
    - if R5 = 0, end of frame;
    - otherwise enter the adjust state with adj_cnt = 0.
  - At end of row with row_cnt < R4, row_cnt increments.
  - In adjust, ra keeps incrementing each line (wraps modulo 2^RA_WIDTH) and adj_cnt increments. At end of line with adj_cnt = R5-1, end of frame.
- States: ACTIVE (rows 0..R4) and ADJUST (R5 extra lines).
  - ACTIVE -> ADJUST on the last line of row R4 when R5 != 0.
  - ADJUST -> ACTIVE at end of frame.
  - ACTIVE -> ACTIVE at end of frame when R5 = 0.
- End of frame: row_cnt, ra and adj_cnt go to 0; ma_row and ma load {R13[5:0],R12} (truncated to MA_WIDTH).
  - The start address is sampled only here; mid-frame writes to R12/R13 do not move the picture.
- MA: ma = ma_row + h_cnt.
  - At end of row (not in ADJUST), ma_row <= ma_row + R1.
  - Within a row, ma repeats for every scan line.
- Output registers:
  - Outputs update on the same clk16 edge as the counters and describe the character cell now current.
  - Outputs hold between char_en strobes.
- de = (h_cnt < R1) and (row_cnt < R6) and ACTIVE.
  - R1 = 0 or R6 = 0 means de is never asserted.
- hsync is high for h_cnt in [R2, R2+W), where W = R3[3:0] or 16 if zero.
  - The compare is 9-bit, so the pulse truncates at end of line (no wrap into the next line).
- vsync rises at the start of line 0 of row R7 and stays high for VSYNC_LINES scan lines, counted across row, adjust and frame boundaries.
  - If R7 > R4, vsync never fires.
  - A new trigger while vsync is high restarts the count.

Test Plan:
- Reset: hold res_b low 3 cycles with char_en toggling -> hsync=vsync=de=0, ma=0, ra=0; reading R0 returns 63 one cycle after reg_re.
- Line timing: R0=9, R1=4, R2=6, R3=2, char_en every cycle -> line period 10; de high for h_cnt 0..3; hsync high for h_cnt 6..7; ma = 0,1,2,3 in the first row.
- Frame timing: additionally R9=1, R4=2, R5=1, R6=2, R7=1, VSYNC_LINES=4:
  - frame is 7 lines = 70 char times;
  - ma_row is 0,4,8 per row, and ra is 0,1 within each row;
  - the adjust line shows ra=2 and de=0;
  - vsync rises at line 2 and lasts 4 lines.
- Start address: write R12=0x10 mid-frame -> current frame unchanged; the first char of the next frame shows ma=0x10.
- Edge cases:
  - R3=0 gives a 16-char hsync clipped at the end of line.
  - Writing R0=2 while h_cnt=7 wraps at the next char_en.
  - char_en held low 5 cycles freezes all outputs.
- Register file: write 0xA5 to R17 then read -> 0xA5; write/read address 20 -> reads 0; simultaneous reg_we and reg_re to R1 returns the old value.
